// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO
// Register window: TXDATA, STATUS, DIVISOR, reserved; selected by adr[3:2].
module mmio_uart_tx #(
  parameter logic [31:0] BASE      = 32'hFFFF_FF00,
  parameter int          DEPTH     = 8,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   period_q, period_d;
  logic          tx_q, tx_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q, div_d;
  logic [7:0]    fifo_q [DEPTH];

  logic       wr, push_req, push_ok, clr, div_wr, pop, empty, full, bit_end, busy;
  logic [1:0] reg_idx;
  logic [7:0] count8;
  logic       unused_bits;

  assign sel         = (adr[31:4] == BASE[31:4]);
  assign reg_idx     = adr[3:2];
  assign wr          = memwrite & sel;
  assign push_req    = wr && (reg_idx == 2'd0);
  assign clr         = wr && (reg_idx == 2'd1) && writedata[3];
  assign div_wr      = wr && (reg_idx == 2'd2);
  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_FULL);
  assign bit_end     = (baud_q == period_q - 16'd1);
  assign count8      = 8'(count_q);
  assign unused_bits = ^{adr[1:0], writedata[31:16]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      period_q <= DIV_RESET;
      tx_q     <= 1'b1;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DIV_RESET;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      period_q <= period_d;
      tx_q     <= tx_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) fifo_q[wptr_q] <= writedata[7:0];
  end

  // Stop bit may chain straight into the next start bit when a byte is waiting.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 16'd1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    period_d = period_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop      = 1'b1;
          state_d  = S_START;
          shift_d  = fifo_q[rptr_q];
          period_d = div_q;
        end
      end
      S_START: if (bit_end) begin
        state_d = S_DATA;
        bit_d   = '0;
        baud_d  = '0;
      end
      S_DATA: if (bit_end) begin
        baud_d = '0;
        bit_d  = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: if (bit_end) begin
        baud_d = '0;
        if (!empty) begin
          pop      = 1'b1;
          state_d  = S_START;
          shift_d  = fifo_q[rptr_q];
          period_d = div_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push_ok = push_req && (!full || pop);
    wptr_d  = push_ok ? wptr_q + PTR_ONE : wptr_q;
    rptr_d  = pop ? rptr_q + PTR_ONE : rptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (clr) ovf_d = 1'b0;
    if (push_req && !push_ok) ovf_d = 1'b1;
    div_d = div_q;
    if (div_wr) div_d = (writedata[15:0] == 16'd0) ? 16'd1 : writedata[15:0];
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[bit_d];
      default: tx_d = 1'b1;
    endcase
    rdata = '0;
    if (sel) begin
      case (reg_idx)
        2'd1:    rdata = {16'h0, count8, 4'h0, ovf_q, empty, full, busy};
        2'd2:    rdata = {16'h0, div_q};
        default: rdata = '0;
      endcase
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - randomized self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'hFFFF_FF00;
  localparam int          DEPTH = 8;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_DIV = BASE + 32'h8;
  localparam logic [31:0] A_RSV = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] writedata = '0;
  logic        memwrite = 1'b0;
  logic        sel;
  logic [31:0] rdata;
  logic        tx;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] bytes_buf [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmio_uart_tx #(.BASE(BASE), .DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
    .clk(clk), .reset(reset), .adr(adr), .writedata(writedata),
    .memwrite(memwrite), .sel(sel), .rdata(rdata), .tx(tx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] st(input int cnt, input bit ovf, input bit bsy);
    return (32'(cnt) << 8) | (32'(ovf) << 3) | (32'(cnt == 0) << 2)
         | (32'(cnt == DEPTH) << 1) | 32'(bsy);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    adr = a; writedata = d; memwrite = 1'b1;
    @(posedge clk); #1;
    memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    adr = a; memwrite = 1'b0;
    @(negedge clk);
    d = rdata;
    @(posedge clk); #1;
  endtask

  // Expected line: two idle samples, then contiguous 10-bit frames of p cycles per bit.
  task automatic run_frames(input int p, input int n, input string tag);
    logic exp_tx[$];
    logic exp_busy[$];
    logic s_tx[$];
    logic [31:0] s_rd[$];
    logic [31:0] s_adr[$];
    logic [9:0] fr;
    logic [31:0] v;
    int len;
    bus_wr(A_DIV, p);
    exp_tx = '{1'b1, 1'b1};
    exp_busy = '{1'b0, 1'b0};
    for (int k = 0; k < n; k++) begin
      fr = {1'b1, bytes_buf[k], 1'b0};
      for (int b = 0; b < 10; b++)
        repeat (p) begin exp_tx.push_back(fr[b]); exp_busy.push_back(1'b1); end
    end
    repeat (4) begin exp_tx.push_back(1'b1); exp_busy.push_back(1'b0); end
    len = exp_tx.size();
    fork
      begin
        for (int k = 0; k < n; k++) bus_wr(A_TX, {24'h0, bytes_buf[k]});
        adr = A_ST;
      end
      begin
        repeat (len) begin
          @(negedge clk);
          s_tx.push_back(tx); s_rd.push_back(rdata); s_adr.push_back(adr);
        end
      end
    join
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s tx[%0d]", tag, i), 32'(s_tx[i]), 32'(exp_tx[i]));
      if (s_adr[i] == A_ST)
        chk($sformatf("%s busy[%0d]", tag, i), 32'(s_rd[i][0]), 32'(exp_busy[i]));
    end
    @(posedge clk); #1;
    rd(A_ST, v);
    chk({tag, " status_end"}, v, st(0, 0, 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int e, lows;
    reset = 1'b1;
    adr = 32'h0;
    @(negedge clk);
    chk("sel_adr0_in_reset", 32'(sel), 0);
    adr = A_ST;
    @(negedge clk);
    chk("sel_base_in_reset", 32'(sel), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("tx_reset", 32'(tx), 1);
    rd(A_ST, v);  chk("status_reset", v, 32'h4);
    rd(A_DIV, v); chk("div_reset", v, 32'd434);
    adr = 32'h0;
    @(negedge clk);
    chk("sel_adr0", 32'(sel), 0);
    chk("rdata_adr0", rdata, 0);
    @(posedge clk); #1;

    bytes_buf[0] = 8'hA5;
    run_frames(2, 1, "a5");
    bytes_buf[0] = 8'h00; bytes_buf[1] = 8'hFF;
    run_frames(1, 2, "b2b");
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 4; k++) bytes_buf[k] = 8'($urandom);
      run_frames(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), $sformatf("rnd%0d", it));
    end

    bus_wr(A_DIV, 16);
    bus_wr(A_TX, $urandom);
    e = cyc;
    idle(3);
    for (int k = 0; k < DEPTH + 1; k++) bus_wr(A_TX, $urandom);
    rd(A_ST, v);  chk("status_overflow", v, st(DEPTH, 1, 1));
    bus_wr(A_ST, 32'h8);
    rd(A_ST, v);  chk("status_ovf_clear", v, st(DEPTH, 0, 1));
    while (cyc < e + 10 * 16) idle(1);
    bus_wr(A_TX, $urandom);
    rd(A_ST, v);  chk("push_full_on_pop", v, st(DEPTH, 0, 1));

    reset = 1'b1; idle(2); reset = 1'b0;
    bus_wr(A_DIV, 4);
    for (int k = 0; k < 4; k++) bus_wr(A_TX, $urandom);
    idle(14);
    rd(A_ST, v);  chk("status_before_reset", v, st(3, 0, 1));
    reset = 1'b1; idle(1); reset = 1'b0;
    chk("tx_after_midreset", 32'(tx), 1);
    rd(A_ST, v);  chk("status_after_midreset", v, 32'h4);
    rd(A_DIV, v); chk("div_after_midreset", v, 32'd434);
    lows = 0;
    repeat (100) begin @(negedge clk); if (!tx) lows++; end
    chk("no_frame_after_reset", 32'(lows), 0);
    @(posedge clk); #1;

    bus_wr(A_DIV, 0);
    rd(A_DIV, v); chk("div_zero_as_one", v, 1);
    rd(A_RSV, v); chk("rsv_read", v, 0);
    bus_wr(A_RSV, 32'hFFFF_FFFF);
    rd(A_DIV, v); chk("div_after_rsv_wr", v, 1);
    rd(A_ST, v);  chk("status_after_rsv_wr", v, 32'h4);
    rd(A_TX, v);  chk("txdata_read", v, 0);
    adr = BASE + 32'h10;
    @(negedge clk);
    chk("sel_outside", 32'(sel), 0);
    chk("rdata_outside", rdata, 0);
    @(posedge clk); #1;
    bus_wr(BASE + 32'h10, 32'h55);
    rd(A_ST, v);  chk("status_after_outside_wr", v, 32'h4);
    chk("tx_idle_end", 32'(tx), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
